// File: rtl/ntt_perm_pkg.sv
// ntt_perm_pkg: shared types and address helpers for the NTT stream permutation buffer
package ntt_perm_pkg;

    typedef enum logic [1:0] {
        PERM_IDENT  = 2'd0,
        PERM_BITREV = 2'd1,
        PERM_STRIDE = 2'd2
    } perm_mode_t;

    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    // Reverse the low log_n bits of i; upper bits of the result are zero.
    function automatic logic [31:0] bitrev_addr(input logic [31:0] i, input int log_n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++)
            if (k < log_n) r[log_n-1-k] = i[k];
        return r;
    endfunction

    // i = {a, b} with b the low stride_log bits; result is {b, a} over log_n bits.
    function automatic logic [31:0] stride_addr(input logic [31:0] i, input int log_n, input int stride_log);
        logic [31:0] lo;
        lo = i & ((32'd1 << stride_log) - 32'd1);
        return (lo << (log_n - stride_log)) | (i >> stride_log);
    endfunction

endpackage

// File: rtl/ntt_perm_bank_ram.sv
// ntt_perm_bank_ram: simple dual-port RAM, one write port, one registered read port
module ntt_perm_bank_ram #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port; storage is never cleared
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Registered read; only the output register is reset
    always_ff @(posedge clk)
        rdata <= rst ? '0 : mem[raddr];

endmodule

// File: rtl/ntt_stream_permute.sv
// ntt_stream_permute: ping-pong frame permutation buffer (identity / bit-reverse / stride); stride mode enabled by NTT_PERM_STRIDE_EN
module ntt_stream_permute
    import ntt_perm_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int LOG_N      = 11,
    parameter int STRIDE_LOG = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_start,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  in_err
);

    if (STRIDE_LOG < 1 || STRIDE_LOG >= LOG_N) begin : g_bad_stride
        $error("STRIDE_LOG must satisfy 0 < STRIDE_LOG < LOG_N");
    end

    wr_state_t        w_state, w_state_n;
    logic [LOG_N-1:0] w_idx, w_idx_n, w_addr, addr_br;
    logic             w_bank, w_bank_n, we, rd_req, err_n;
    logic [1:0]       mode_q, mode_n;
    rd_state_t        r_state, r_state_n;
    logic [LOG_N-1:0] r_idx, r_idx_n;
    logic             r_bank, r_bank_n;

    assign addr_br = LOG_N'(bitrev_addr(32'(w_idx), LOG_N));
`ifdef NTT_PERM_STRIDE_EN
    logic [LOG_N-1:0] addr_st;
    assign addr_st = LOG_N'(stride_addr(32'(w_idx), LOG_N, STRIDE_LOG));
    assign w_addr  = mode_q == PERM_BITREV ? addr_br : mode_q == PERM_STRIDE ? addr_st : w_idx;
`else
    assign w_addr  = mode_q == PERM_BITREV ? addr_br : w_idx;
`endif

    // Write side: accept frames, abort on an early start, hand completed banks to the reader
    always_comb begin
        w_state_n = w_state;
        w_idx_n   = w_idx;
        w_bank_n  = w_bank;
        mode_n    = mode_q;
        err_n     = 1'b0;
        we        = 1'b0;
        rd_req    = 1'b0;
        if (in_valid && in_start) begin
            we        = 1'b1;
            err_n     = w_state == W_FILL;
            mode_n    = in_mode;
            w_idx_n   = LOG_N'(1);
            w_state_n = W_FILL;
        end else if (in_valid && w_state == W_FILL) begin
            we      = 1'b1;
            w_idx_n = w_idx + 1'b1;
            if (&w_idx) begin
                rd_req    = 1'b1;
                w_bank_n  = ~w_bank;
                w_state_n = W_IDLE;
            end
        end
    end

    // Read side: drain sequentially; a request on the last read restarts with no bubble
    always_comb begin
        r_state_n = r_state;
        r_idx_n   = r_idx;
        r_bank_n  = r_bank;
        if (r_state == R_DRAIN) begin
            r_idx_n = r_idx + 1'b1;
            if (&r_idx) r_state_n = R_IDLE;
        end
        if (rd_req) begin
            r_state_n = R_DRAIN;
            r_idx_n   = '0;
            r_bank_n  = w_bank;
        end
    end

    // State registers and output flags aligned with the one-cycle RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_bank    <= 1'b0;
            mode_q    <= PERM_IDENT;
            r_state   <= R_IDLE;
            r_idx     <= '0;
            r_bank    <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            in_err    <= 1'b0;
        end else begin
            w_state   <= w_state_n;
            w_idx     <= w_idx_n;
            w_bank    <= w_bank_n;
            mode_q    <= mode_n;
            r_state   <= r_state_n;
            r_idx     <= r_idx_n;
            r_bank    <= r_bank_n;
            out_valid <= r_state == R_DRAIN;
            out_start <= r_state == R_DRAIN && r_idx == '0;
            in_err    <= err_n;
        end
    end

    ntt_perm_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(LOG_N + 1)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr({w_bank, in_start ? LOG_N'(0) : w_addr}),
        .wdata(in_data),
        .raddr({r_bank, r_idx}),
        .rdata(out_data)
    );

endmodule

// File: tb/tb_ntt_stream_permute.sv
// tb_ntt_stream_permute: directed self-checking bench for ntt_stream_permute (LOG_N=4, STRIDE_LOG=2)
module tb_ntt_stream_permute;

    localparam int DW = 28;
    localparam int LN = 4;
    localparam int SL = 2;
    localparam int N  = 16;

    logic          clk = 1'b0, rst = 1'b1, in_start = 1'b0, in_valid = 1'b0;
    logic [1:0]    in_mode = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic          out_start, out_valid, in_err;
    logic [DW-1:0] out_data;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int outq[$], startq[$], cycq[$], errq[$];

    int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`ifdef NTT_PERM_STRIDE_EN
    int st[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
`else
    int st[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

    ntt_stream_permute #(.DATA_WIDTH(DW), .LOG_N(LN), .STRIDE_LOG(SL)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid),
        .in_data(in_data), .in_mode(in_mode), .out_start(out_start),
        .out_valid(out_valid), .out_data(out_data), .in_err(in_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            outq.push_back(int'(out_data));
            startq.push_back(int'(out_start));
            cycq.push_back(cyc);
        end
        if (in_err) errq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int expv(input int m, input int k);
        return m == 1 ? br[k] : m == 2 ? st[k] : k;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [1:0] m, input int d);
        @(negedge clk);
        in_valid = v;
        in_start = s;
        in_mode  = m;
        in_data  = DW'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 2'd0, 0);
    endtask

    task automatic send_frame(input logic [1:0] m, input bit gap, output int last);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, k == 0, m, k);
            if (gap && k != N - 1) drive(1'b0, 1'b0, 2'd0, 0);
        end
        last = cyc;
    endtask

    task automatic clear_q();
        outq.delete();
        startq.delete();
        cycq.delete();
        errq.delete();
    endtask

    task automatic check_frame(input string tag, input int off, input int m, input int first);
        for (int k = 0; k < N; k++) begin
            bit have;
            have = outq.size() > off + k;
            check($sformatf("%s_data[%0d]", tag, k), have ? outq[off+k] : -1, expv(m, k));
            check($sformatf("%s_start[%0d]", tag, k), have ? startq[off+k] : -1, int'(k == 0));
            check($sformatf("%s_cyc[%0d]", tag, k), have ? cycq[off+k] : -1, first + k);
        end
    endtask

    initial begin
        int l1, l2, l3;
        bit found;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_err", in_err, 0);
        rst = 1'b0;
        idle(2);

        clear_q();
        send_frame(2'd1, 1'b0, l1);
        idle(22);
        check("brv_count", outq.size(), N);
        check_frame("brv", 0, 1, l1 + 2);

        clear_q();
        send_frame(2'd2, 1'b0, l1);
        idle(22);
        check("str_count", outq.size(), N);
        check_frame("str", 0, 2, l1 + 2);

        clear_q();
        send_frame(2'd0, 1'b0, l1);
        send_frame(2'd1, 1'b0, l2);
        send_frame(2'd2, 1'b0, l3);
        idle(22);
        check("b2b_count", outq.size(), 3 * N);
        check("b2b_err", errq.size(), 0);
        check_frame("b2b0", 0, 0, l1 + 2);
        check_frame("b2b1", N, 1, l1 + 2 + N);
        check_frame("b2b2", 2 * N, 2, l1 + 2 + 2 * N);

        clear_q();
        send_frame(2'd0, 1'b1, l1);
        idle(22);
        check("gap_count", outq.size(), N);
        check_frame("gap", 0, 0, l1 + 2);

        clear_q();
        for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 2'd0, 100 + k);
        send_frame(2'd1, 1'b0, l1);
        idle(22);
        check("abort_err_count", errq.size(), 1);
        check("abort_err_cyc", errq.size() > 0 ? errq[0] : -1, l1 - (N - 1) + 1);
        check("abort_count", outq.size(), N);
        check_frame("abort", 0, 1, l1 + 2);

        clear_q();
        send_frame(2'd0, 1'b0, l1);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            found = out_valid && out_data == DW'(7);
            in_valid = 1'b0;
            in_start = 1'b0;
        end
        check("mid_rst_seen", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_start", out_start, 0);
        check("mid_rst_out_data", out_data, 0);
        rst = 1'b0;
        idle(20);
        check("mid_rst_no_resume", outq.size(), 8);
        clear_q();
        send_frame(2'd1, 1'b0, l1);
        idle(22);
        check("post_rst_count", outq.size(), N);
        check_frame("post_rst", 0, 1, l1 + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ntt_stream_permute.md
# ntt_stream_permute

Streaming, parametrised permutation buffer for the NTT datapath. It accepts one coefficient per cycle in frames of N = 2^LOG_N elements and reorders each frame by a per-frame mode: identity, bit-reversal or stride permutation. It emits the reordered frame one element per cycle. It is a ping-pong (double-buffered) successor to the single-stage serial permutation wrapper, and sits between NTT butterfly stages and the external stream interface.

## Interface
Parameters:
- DATA_WIDTH, 28, width of one coefficient
- LOG_N, 11, log2 of frame length N (N = 2048)
- STRIDE_LOG, 6, log2 of stride S for stride mode (S = 64); must satisfy 0 < STRIDE_LOG < LOG_N

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_start  in  1  marks first element of a frame; qualified by in_valid
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_WIDTH  input coefficient
- in_mode  in  2  permutation mode, sampled on accepted in_start
- out_start  out  1  marks first element of an output frame
- out_valid  out  1  out_data valid
- out_data  out  DATA_WIDTH  permuted coefficient
- in_err  out  1  one-cycle pulse: frame aborted

## Operation
- Two banks of N words. The write bank takes the incoming frame; the read bank is drained sequentially.
- Write side has states W_IDLE and W_FILL:
  - W_IDLE: in_valid&in_start accepts element 0, latches mode, goes to W_FILL with write index 1. in_valid without in_start is dropped.
  - W_FILL: each in_valid writes element i at addr(i) and increments i. At i = N-1 the frame is complete: flip banks, raise a read request, return to W_IDLE.
  - in_valid&in_start while in W_FILL: pulse in_err, discard the partial frame, and treat the element as element 0 of a new frame.
- Write address by mode:
  - 0 identity: addr = i.
  - 1 bit-reverse: addr = bitrev(i) over LOG_N bits.
  - 2 stride: i = {a, b} with b the low STRIDE_LOG bits, addr = {b, a}.
  - 3: reserved, behaves as identity.
- Read side has states R_IDLE and R_DRAIN:
  - R_IDLE: on read request, go to R_DRAIN with read index 0.
  - R_DRAIN: read address j for j = 0..N-1, one per cycle, then return to R_IDLE.
  - If a new read request coincides with the last read (back-to-back frames), go directly to index 0 of the new bank with no bubble.
- Input gaps (in_valid low) are allowed mid-frame. Output is always gapless within a frame.
- Rate limit is one element per cycle, so a frame cannot complete before the previous read drains. No backpressure exists.

## Timing
- RAM read is synchronous, 1 cycle.
- Last input element accepted at cycle T gives out_start = out_valid = 1 with output element 0 at T+2. Output elements 1..N-1 follow at T+3..T+N+1.
- out_start is high exactly one cycle per frame, coincident with output element 0.
- Back-to-back contiguous input frames give a contiguous output stream with no idle cycle.
- in_err asserts in the cycle after the offending in_start.
- Reset values: out_start=0, out_valid=0, out_data=0, in_err=0. Both FSMs go to IDLE, indices go to 0, bank select goes to 0, latched mode goes to identity.
- Reset mid-operation: in-flight and buffered frames are lost, and out_valid=0 from the next cycle. RAM contents are not cleared.

## Configuration
- NTT_PERM_STRIDE_EN defined: mode 2 performs the stride permutation.
- NTT_PERM_STRIDE_EN undefined: the stride address logic is absent and mode 2 behaves as identity. Latency and all other modes are unchanged.

## Structure
- Package ntt_perm_pkg holds:
  - typedef enum perm_mode_t {PERM_IDENT=0, PERM_BITREV=1, PERM_STRIDE=2}
  - functions bitrev_addr and stride_addr
  - FSM state typedefs
- Sub-module ntt_perm_bank_ram: simple dual-port RAM, one write port and one registered read port, depth 2N (bank bit as MSB), width DATA_WIDTH.

## Test plan
Bench parameters: LOG_N=4, STRIDE_LOG=2, data = index.
- Bit-reverse: mode 1, frame 0..15 contiguous -> output 0,8,4,12,2,10,6,14,1,9,..., with out_start 2 cycles after element 15.
- Stride: mode 2 -> output 0,4,8,12,1,5,9,13,2,... With the macro undefined, the same stimulus -> 0,1,2,...,15.
- Back-to-back: three frames, modes 0,1,2, no gaps -> 48 contiguous outputs, three out_start pulses 16 cycles apart, each frame in its correct order.
- Gaps: identity frame with in_valid low on alternate cycles -> output 0..15 contiguous, starting 2 cycles after the last input.
- Abort: in_start at element 5 -> in_err pulse. The first 5 elements never appear; the new frame outputs correctly.
- Reset mid-drain at output element 7 -> out_valid=0 next cycle. A new frame after reset outputs correctly.
